// File: rtl/neuron_scan_sequencer.sv
// neuron_scan_sequencer: steps through every (neuron address, sub-cycle phase) slot once per timestep.
// External requests pause the sweep without losing its position. The block also flags sweep completion
// and timesteps that arrive before the previous sweep has finished.
module neuron_scan_sequencer #(
    parameter int NEURON_NO          = 256,
    parameter int PHASES             = 2,
    parameter int REQ_CH             = 2,
    parameter int RESTART_ON_OVERRUN = 0,
    parameter int CNT_W              = 16,
    localparam int ADDR_W            = $clog2(NEURON_NO),
    localparam int PH_W              = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sys_en,
    input  logic [REQ_CH-1:0] ext_req,
    input  logic              dt_tick,
    output logic              scan_en,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [PH_W-1:0]   scan_phase,
    output logic              last_phase,
    output logic              busy,
    output logic              stall,
    output logic              sweep_done,
    output logic              overrun,
    output logic [CNT_W-1:0]  sweep_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NEURON_NO - 1);
    localparam logic [PH_W-1:0]   LAST_PHASE = PH_W'(PHASES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [PH_W-1:0]   r_phase;
    logic              r_sweepDone;
    logic              r_overrun;
    logic [CNT_W-1:0]  r_sweepCnt;

    state_t            w_nextState;
    logic [ADDR_W-1:0] w_nextAddr;
    logic [PH_W-1:0]   w_nextPhase;
    logic              w_nextDone;
    logic              w_nextOverrun;
    logic [CNT_W-1:0]  w_nextCnt;

    logic              w_anyReq;
    logic              w_busy;
    logic              w_scanEn;
    logic              w_lastPhase;
    logic              w_finalSlot;

    // A slot is consumed only while scanning, enabled and free of external requests.
    always_comb begin
        w_anyReq    = |ext_req;
        w_busy      = (r_state == S_SCAN);
        w_scanEn    = w_busy & sys_en & ~w_anyReq;
        w_lastPhase = (r_phase == LAST_PHASE);
        w_finalSlot = w_scanEn & w_lastPhase & (r_addr == LAST_ADDR);
    end

    // Next-state logic. With sys_en low every register holds, except the pulses, which fall to zero.
    always_comb begin
        w_nextState   = r_state;
        w_nextAddr    = r_addr;
        w_nextPhase   = r_phase;
        w_nextDone    = 1'b0;
        w_nextOverrun = 1'b0;
        w_nextCnt     = r_sweepCnt;
        if (sys_en) begin
            case (r_state)
                S_IDLE: begin
                    if (dt_tick) begin
                        w_nextState = S_SCAN;
                        w_nextAddr  = '0;
                        w_nextPhase = '0;
                    end
                end
                S_SCAN: begin
                    if (w_finalSlot) begin
                        // A tick on the closing edge is a clean back-to-back restart, not an overrun.
                        w_nextDone  = 1'b1;
                        w_nextCnt   = r_sweepCnt + CNT_W'(1);
                        w_nextAddr  = '0;
                        w_nextPhase = '0;
                        if (!dt_tick) begin
                            w_nextState = S_IDLE;
                        end
                    end else begin
                        if (w_scanEn) begin
                            if (w_lastPhase) begin
                                w_nextPhase = '0;
                                w_nextAddr  = r_addr + ADDR_W'(1);
                            end else begin
                                w_nextPhase = r_phase + PH_W'(1);
                            end
                        end
                        if (dt_tick) begin
                            w_nextOverrun = 1'b1;
                            if (RESTART_ON_OVERRUN != 0) begin
                                w_nextAddr  = '0;
                                w_nextPhase = '0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // State and position registers. Reset abandons any sweep in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_phase     <= '0;
            r_sweepDone <= 1'b0;
            r_overrun   <= 1'b0;
            r_sweepCnt  <= '0;
        end else begin
            r_state     <= w_nextState;
            r_addr      <= w_nextAddr;
            r_phase     <= w_nextPhase;
            r_sweepDone <= w_nextDone;
            r_overrun   <= w_nextOverrun;
            r_sweepCnt  <= w_nextCnt;
        end
    end

    // Drive the output ports.
    always_comb begin
        scan_en    = w_scanEn;
        scan_addr  = r_addr;
        scan_phase = r_phase;
        last_phase = w_lastPhase;
        busy       = w_busy;
        stall      = w_busy & w_anyReq & sys_en;
        sweep_done = r_sweepDone;
        overrun    = r_overrun;
        sweep_cnt  = r_sweepCnt;
    end

endmodule

// File: tb/tb_neuron_scan_sequencer.sv
// Testbench for neuron_scan_sequencer with three instances:
//   dut0: 4 neurons, 2 phases, overrun is ignored
//   dut1: 4 neurons, 2 phases, overrun restarts the sweep
//   dut2: 4 neurons, 1 phase, 2-bit sweep counter
// A reference model tracks sweep position as a single linear slot index.
module tb_neuron_scan_sequencer;

    localparam int NN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN  [3];
    logic       sysEn [3];
    logic [1:0] req   [3];
    logic       tick  [3];

    logic       oSe    [3];
    logic       oLast  [3];
    logic       oBusy  [3];
    logic       oStall [3];
    logic       oDone  [3];
    logic       oOvr   [3];
    logic [1:0] oAddr  [3];
    logic [0:0] oPh    [3];
    logic [15:0] oCnt0;
    logic [15:0] oCnt1;
    logic [1:0]  oCnt2;

    int tests = 0;
    int fails = 0;

    bit mBusy [3] = '{default: 1'b0};
    int mSlot [3] = '{default: 0};
    int mCnt  [3] = '{default: 0};
    bit mDone [3] = '{default: 1'b0};
    bit mOvr  [3] = '{default: 1'b0};

    int seCnt    [3] = '{default: 0};
    int busyCnt  [3] = '{default: 0};
    int stallCnt [3] = '{default: 0};

    neuron_scan_sequencer #(.NEURON_NO(NN), .PHASES(2), .REQ_CH(2), .RESTART_ON_OVERRUN(0), .CNT_W(16)) u0 (
        .clk(clk), .reset(rstN[0]), .sys_en(sysEn[0]), .ext_req(req[0]), .dt_tick(tick[0]),
        .scan_en(oSe[0]), .scan_addr(oAddr[0]), .scan_phase(oPh[0]), .last_phase(oLast[0]),
        .busy(oBusy[0]), .stall(oStall[0]), .sweep_done(oDone[0]), .overrun(oOvr[0]), .sweep_cnt(oCnt0));

    neuron_scan_sequencer #(.NEURON_NO(NN), .PHASES(2), .REQ_CH(2), .RESTART_ON_OVERRUN(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(rstN[1]), .sys_en(sysEn[1]), .ext_req(req[1]), .dt_tick(tick[1]),
        .scan_en(oSe[1]), .scan_addr(oAddr[1]), .scan_phase(oPh[1]), .last_phase(oLast[1]),
        .busy(oBusy[1]), .stall(oStall[1]), .sweep_done(oDone[1]), .overrun(oOvr[1]), .sweep_cnt(oCnt1));

    neuron_scan_sequencer #(.NEURON_NO(NN), .PHASES(1), .REQ_CH(2), .RESTART_ON_OVERRUN(0), .CNT_W(2)) u2 (
        .clk(clk), .reset(rstN[2]), .sys_en(sysEn[2]), .ext_req(req[2]), .dt_tick(tick[2]),
        .scan_en(oSe[2]), .scan_addr(oAddr[2]), .scan_phase(oPh[2]), .last_phase(oLast[2]),
        .busy(oBusy[2]), .stall(oStall[2]), .sweep_done(oDone[2]), .overrun(oOvr[2]), .sweep_cnt(oCnt2));

    function automatic int phasesOf(int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic int cntMod(int i);
        return (i == 2) ? 4 : 65536;
    endfunction

    function automatic bit restartOf(int i);
        return (i == 1);
    endfunction

    function automatic int dutCnt(int i);
        if (i == 0) return int'(oCnt0);
        if (i == 1) return int'(oCnt1);
        return int'(oCnt2);
    endfunction

    // One comparison: count it, and report it if the values differ.
    task automatic checkOutput(string nm, int i, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s dut%0d actual=%0d expected=%0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic modelReset(int i);
        mBusy[i] = 1'b0;
        mSlot[i] = 0;
        mCnt[i]  = 0;
        mDone[i] = 1'b0;
        mOvr[i]  = 1'b0;
    endtask

    // Advance the model by one clock edge, using a linear slot index 0..NN*PHASES-1.
    task automatic modelStep(int i);
        bit consume;
        mDone[i] = 1'b0;
        mOvr[i]  = 1'b0;
        if (!sysEn[i]) return;
        if (!mBusy[i]) begin
            if (tick[i]) begin
                mBusy[i] = 1'b1;
                mSlot[i] = 0;
            end
        end else begin
            consume = (req[i] == 2'b00);
            if (consume && mSlot[i] == NN * phasesOf(i) - 1) begin
                mDone[i] = 1'b1;
                mCnt[i]  = (mCnt[i] + 1) % cntMod(i);
                mSlot[i] = 0;
                mBusy[i] = tick[i];
            end else begin
                if (consume) mSlot[i] = mSlot[i] + 1;
                if (tick[i]) begin
                    mOvr[i] = 1'b1;
                    if (restartOf(i)) mSlot[i] = 0;
                end
            end
        end
    endtask

    // Model update. Asynchronous resets are only dropped while clk is low, so clk==1 marks a real clock edge.
    always @(posedge clk or negedge rstN[0] or negedge rstN[1] or negedge rstN[2]) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstN[i]) modelReset(i);
            else if (clk) modelStep(i);
        end
    end

    // Compare every output of every instance against the model on each falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int p;
            bit eSe;
            bit eStall;
            p      = phasesOf(i);
            eSe    = mBusy[i] && sysEn[i] && (req[i] == 2'b00);
            eStall = mBusy[i] && sysEn[i] && (req[i] != 2'b00);
            checkOutput("scan_en",    i, int'(oSe[i]),    int'(eSe));
            checkOutput("stall",      i, int'(oStall[i]), int'(eStall));
            checkOutput("busy",       i, int'(oBusy[i]),  int'(mBusy[i]));
            checkOutput("scan_addr",  i, int'(oAddr[i]),  mSlot[i] / p);
            checkOutput("scan_phase", i, int'(oPh[i]),    mSlot[i] % p);
            checkOutput("last_phase", i, int'(oLast[i]),  int'((mSlot[i] % p) == p - 1));
            checkOutput("sweep_done", i, int'(oDone[i]),  int'(mDone[i]));
            checkOutput("overrun",    i, int'(oOvr[i]),   int'(mOvr[i]));
            checkOutput("sweep_cnt",  i, dutCnt(i),       mCnt[i]);
            if (oSe[i] === 1'b1)    seCnt[i]++;
            if (oBusy[i] === 1'b1)  busyCnt[i]++;
            if (oStall[i] === 1'b1) stallCnt[i]++;
        end
    end

    // Drive the inputs of one instance and let one clock edge sample them.
    task automatic applyStimulus(int i, bit s, logic [1:0] r, bit t);
        sysEn[i] = s;
        req[i]   = r;
        tick[i]  = t;
        @(posedge clk);
        #2;
    endtask

    task automatic runPlain(int i, int n);
        for (int k = 0; k < n; k++) applyStimulus(i, 1'b1, 2'b00, 1'b0);
    endtask

    // Directed scenarios with hand-computed expected values.
    initial begin
        int s0;
        int b0;
        int st0;
        int expCnt [5];
        expCnt = '{1, 2, 3, 0, 1};
        sysEn  = '{1'b1, 1'b1, 1'b1};
        req    = '{2'b00, 2'b00, 2'b00};
        tick   = '{1'b0, 1'b0, 1'b0};
        rstN   = '{1'b1, 1'b1, 1'b1};
        #1;
        rstN = '{1'b0, 1'b0, 1'b0};
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("rst_busy", 0, int'(oBusy[0]), 0);
        checkOutput("rst_addr", 0, int'(oAddr[0]), 0);
        checkOutput("rst_cnt",  0, int'(oCnt0),    0);
        checkOutput("rst_done", 0, int'(oDone[0]), 0);
        rstN = '{1'b1, 1'b1, 1'b1};

        // Plain sweep: eight slots, then sweep_done and return to idle.
        s0 = seCnt[0];
        applyStimulus(0, 1'b1, 2'b00, 1'b1);
        checkOutput("s1_first_addr", 0, int'(oAddr[0]), 0);
        checkOutput("s1_first_busy", 0, int'(oBusy[0]), 1);
        runPlain(0, 8);
        checkOutput("s1_scan_cycles", 0, seCnt[0] - s0, 8);
        checkOutput("s1_done", 0, int'(oDone[0]), 1);
        checkOutput("s1_cnt",  0, int'(oCnt0), 1);
        checkOutput("s1_idle", 0, int'(oBusy[0]), 0);
        runPlain(0, 1);
        checkOutput("s1_done_clear", 0, int'(oDone[0]), 0);

        // Three-cycle stall at slot (1,1).
        b0  = busyCnt[0];
        st0 = stallCnt[0];
        applyStimulus(0, 1'b1, 2'b00, 1'b1);
        runPlain(0, 3);
        checkOutput("s2_at_addr",  0, int'(oAddr[0]), 1);
        checkOutput("s2_at_phase", 0, int'(oPh[0]), 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1'b1, 2'b01, 1'b0);
        checkOutput("s2_held_addr",  0, int'(oAddr[0]), 1);
        checkOutput("s2_held_phase", 0, int'(oPh[0]), 1);
        runPlain(0, 5);
        checkOutput("s2_sweep_len",   0, busyCnt[0] - b0, 11);
        checkOutput("s2_stall_count", 0, stallCnt[0] - st0, 3);
        checkOutput("s2_done", 0, int'(oDone[0]), 1);
        checkOutput("s2_cnt",  0, int'(oCnt0), 2);
        runPlain(0, 1);

        // Overrun at slot (2,0) with overrun ignored: position keeps going.
        applyStimulus(0, 1'b1, 2'b00, 1'b1);
        runPlain(0, 4);
        checkOutput("s3_at_addr", 0, int'(oAddr[0]), 2);
        applyStimulus(0, 1'b1, 2'b00, 1'b1);
        checkOutput("s3_ovr",   0, int'(oOvr[0]), 1);
        checkOutput("s3_addr",  0, int'(oAddr[0]), 2);
        checkOutput("s3_phase", 0, int'(oPh[0]), 1);
        runPlain(0, 3);
        checkOutput("s3_done", 0, int'(oDone[0]), 1);
        checkOutput("s3_cnt",  0, int'(oCnt0), 3);
        runPlain(0, 1);

        // Same overrun on the restarting instance.
        applyStimulus(1, 1'b1, 2'b00, 1'b1);
        runPlain(1, 4);
        applyStimulus(1, 1'b1, 2'b00, 1'b1);
        checkOutput("s3r_ovr",   1, int'(oOvr[1]), 1);
        checkOutput("s3r_addr",  1, int'(oAddr[1]), 0);
        checkOutput("s3r_phase", 1, int'(oPh[1]), 0);
        checkOutput("s3r_cnt",   1, int'(oCnt1), 0);
        runPlain(1, 7);
        checkOutput("s3r_not_done", 1, int'(oDone[1]), 0);
        runPlain(1, 1);
        checkOutput("s3r_done", 1, int'(oDone[1]), 1);
        checkOutput("s3r_cnt2", 1, int'(oCnt1), 1);
        runPlain(1, 1);

        // Tick coincident with final-slot consumption.
        applyStimulus(0, 1'b1, 2'b00, 1'b1);
        runPlain(0, 7);
        applyStimulus(0, 1'b1, 2'b00, 1'b1);
        checkOutput("s4_done",  0, int'(oDone[0]), 1);
        checkOutput("s4_ovr",   0, int'(oOvr[0]), 0);
        checkOutput("s4_busy",  0, int'(oBusy[0]), 1);
        checkOutput("s4_addr",  0, int'(oAddr[0]), 0);
        checkOutput("s4_phase", 0, int'(oPh[0]), 0);
        checkOutput("s4_cnt",   0, int'(oCnt0), 4);
        runPlain(0, 8);
        checkOutput("s4_done2", 0, int'(oDone[0]), 1);
        checkOutput("s4_cnt2",  0, int'(oCnt0), 5);
        checkOutput("s4_idle",  0, int'(oBusy[0]), 0);
        runPlain(0, 1);

        // Asynchronous reset in the middle of slot (2,1).
        applyStimulus(0, 1'b1, 2'b00, 1'b1);
        runPlain(0, 5);
        checkOutput("s5_at_addr",  0, int'(oAddr[0]), 2);
        checkOutput("s5_at_phase", 0, int'(oPh[0]), 1);
        #5;
        rstN[0] = 1'b0;
        #1;
        checkOutput("s5_rst_busy",  0, int'(oBusy[0]), 0);
        checkOutput("s5_rst_addr",  0, int'(oAddr[0]), 0);
        checkOutput("s5_rst_phase", 0, int'(oPh[0]), 0);
        checkOutput("s5_rst_cnt",   0, int'(oCnt0), 0);
        checkOutput("s5_rst_se",    0, int'(oSe[0]), 0);
        @(posedge clk);
        #2;
        rstN[0] = 1'b1;
        checkOutput("s5_rst_done", 0, int'(oDone[0]), 0);
        applyStimulus(0, 1'b1, 2'b00, 1'b1);
        checkOutput("s5_restart_addr", 0, int'(oAddr[0]), 0);
        checkOutput("s5_restart_busy", 0, int'(oBusy[0]), 1);
        runPlain(0, 8);
        checkOutput("s5_done", 0, int'(oDone[0]), 1);
        checkOutput("s5_cnt",  0, int'(oCnt0), 1);
        runPlain(0, 1);

        // sys_en low for five cycles mid-sweep, with an ignored tick inside that window.
        applyStimulus(0, 1'b1, 2'b00, 1'b1);
        runPlain(0, 3);
        applyStimulus(0, 1'b0, 2'b00, 1'b0);
        applyStimulus(0, 1'b0, 2'b00, 1'b0);
        applyStimulus(0, 1'b0, 2'b00, 1'b1);
        checkOutput("s6_tick_ignored", 0, int'(oOvr[0]), 0);
        applyStimulus(0, 1'b0, 2'b00, 1'b0);
        applyStimulus(0, 1'b0, 2'b00, 1'b0);
        checkOutput("s6_addr",  0, int'(oAddr[0]), 1);
        checkOutput("s6_phase", 0, int'(oPh[0]), 1);
        checkOutput("s6_busy",  0, int'(oBusy[0]), 1);
        checkOutput("s6_se",    0, int'(oSe[0]), 0);
        runPlain(0, 5);
        checkOutput("s6_done", 0, int'(oDone[0]), 1);
        checkOutput("s6_cnt",  0, int'(oCnt0), 2);
        runPlain(0, 1);

        // Single phase, 2-bit counter, five back-to-back sweeps.
        applyStimulus(2, 1'b1, 2'b00, 1'b1);
        for (int s = 0; s < 5; s++) begin
            runPlain(2, 3);
            checkOutput("s7_last_phase", 2, int'(oLast[2]), 1);
            applyStimulus(2, 1'b1, 2'b00, (s < 4));
            checkOutput("s7_cnt", 2, int'(oCnt2), expCnt[s]);
        end
        runPlain(2, 1);
        checkOutput("s7_idle", 2, int'(oBusy[2]), 0);
        checkOutput("s7_last_phase_idle", 2, int'(oLast[2]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/neuron_scan_sequencer.md
Name: neuron_scan_sequencer

Overview:
Time-multiplexed neuron update sequencer for the neuromorphic core. Each dt_tick starts one sweep over all NEURON_NO neuron addresses, and each address gets PHASES consecutive sub-cycles (read/update/write slots). External requests on any of REQ_CH channels preempt the sweep without losing position. The block sits between the timestep generator and the neuron state memory/update pipeline, and reports sweep completion and timestep overruns.

Parameters:
NEURON_NO, 256, number of neurons per sweep (>=2)
PHASES, 2, sub-cycles per neuron (>=1)
REQ_CH, 2, number of external request channels (>=1)
RESTART_ON_OVERRUN, 0, 0 = ignore a dt_tick that arrives mid-sweep; 1 = restart the sweep at address 0
CNT_W, 16, width of the completed-sweep counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
sys_en  in  1  global enable; 0 freezes all state
ext_req  in  REQ_CH  external access requests; any bit set stalls the sweep
dt_tick  in  1  timestep strobe, one cycle wide
scan_en  out  1  current (scan_addr, scan_phase) slot is valid and consumed at this edge
scan_addr  out  $clog2(NEURON_NO)  neuron address under update
scan_phase  out  max(1,$clog2(PHASES))  sub-cycle index within the neuron
last_phase  out  1  scan_phase==PHASES-1 (combinational)
busy  out  1  sweep in progress (state==SCAN)
stall  out  1  busy & |ext_req & sys_en
sweep_done  out  1  one-cycle registered pulse after the final slot is consumed
overrun  out  1  one-cycle registered pulse when a dt_tick hits mid-sweep
sweep_cnt  out  CNT_W  completed sweeps, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, reset==0): state IDLE, scan_addr 0, scan_phase 0, sweep_done 0, overrun 0, sweep_cnt 0. A reset mid-sweep abandons the sweep. No sweep_done is produced for it.
- scan_en = busy & sys_en & ~|ext_req (Mealy). Slot (A,P) is consumed on any edge where scan_en=1.
- sys_en=0: no register changes, dt_tick is ignored, scan_en=0 and stall=0, and registered pulses clear to 0.
- States: IDLE, SCAN.
- IDLE: dt_tick & sys_en -> SCAN, addr 0, phase 0. The first slot is offered in the next cycle. ext_req does not block entry; it only stalls.
- SCAN on a consumed slot: if phase<PHASES-1, phase+1. Otherwise phase resets to 0 and addr+1.
- SCAN stalled (|ext_req): addr and phase hold, with no limit on stall length.
- Final slot (addr NEURON_NO-1, phase PHASES-1) consumed: next cycle sweep_done=1, sweep_cnt+1, state IDLE, addr 0, phase 0.
- A sweep without stalls takes exactly NEURON_NO*PHASES scan_en cycles.
- dt_tick in SCAN that is not coincident with final-slot consumption: overrun=1 next cycle.
  - RESTART_ON_OVERRUN=0: position is unchanged.
  - RESTART_ON_OVERRUN=1: addr 0, phase 0, no sweep_done, and sweep_cnt is unchanged.
- dt_tick coincident with final-slot consumption: treated as a normal completion followed by an immediate restart. sweep_done=1, sweep_cnt+1, state stays SCAN with addr 0, phase 0, and no overrun.
- dt_tick while stalled in SCAN: counts as an overrun (rules above apply).
- PHASES=1: scan_phase is constant 0, last_phase is constant 1, and addr advances on every consumed slot.
- sweep_cnt wraps from 2^CNT_W-1 to 0 without any flag.

Test Plan:
- NEURON_NO=4, PHASES=2: reset, then one dt_tick, no ext_req -> 8 scan_en cycles with (addr,phase) = (0,0),(0,1),(1,0)…(3,1); sweep_done one cycle after (3,1); sweep_cnt=1; busy=0 afterwards.
- Same sweep with ext_req=2'b01 held 3 cycles while at (1,1) -> stall=1 and scan_en=0 for those 3 cycles; (1,1) is consumed after release; total sweep length is 11 cycles.
- RESTART_ON_OVERRUN=0: dt_tick at slot (2,0) -> overrun pulse; sweep continues to (3,1); sweep_cnt=1. With RESTART_ON_OVERRUN=1, the same stimulus -> overrun, next slot (0,0), and the sweep completes 8 slots later with sweep_cnt=1.
- dt_tick on the same edge as (3,1) is consumed -> sweep_done=1, overrun=0, next slot (0,0), sweep_cnt increments once.
- Drive reset low at slot (2,1) asynchronously (mid-cycle) -> all outputs return to reset values immediately; no sweep_done; the next dt_tick starts at (0,0). Also: sys_en=0 for 5 cycles mid-sweep -> position held, a dt_tick in that window is ignored.
- CNT_W=2, PHASES=1: run 5 back-to-back sweeps -> sweep_cnt sequence 1,2,3,0,1; last_phase is constant 1.
